// File: rtl/clk_pkg.sv
// Shared definitions for the time-setting sequencer and the h/m/s counter.
// Field widths/limits and wrap-aware single-step helpers for the set flow.
package clk_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        COMMIT   = 2'd3
    } state_e;

    // inc and dec together cancel out; wrap points are compared explicitly.
    function automatic logic [HOUR_W-1:0] step_hour(input logic [HOUR_W-1:0] v,
                                                    input logic up, input logic dn);
        logic [HOUR_W-1:0] r;
        r = v;
        if (up && !dn)
            r = (v == HOUR_MAX) ? '0 : v + 1'b1;
        else if (dn && !up)
            r = (v == '0) ? HOUR_MAX : v - 1'b1;
        return r;
    endfunction

    function automatic logic [MIN_W-1:0] step_min(input logic [MIN_W-1:0] v,
                                                  input logic up, input logic dn);
        logic [MIN_W-1:0] r;
        r = v;
        if (up && !dn)
            r = (v == MIN_MAX) ? '0 : v + 1'b1;
        else if (dn && !up)
            r = (v == '0) ? MIN_MAX : v - 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter; tick is high for the wrap cycle.
// clr restarts the count so the next tick lands TICK_DIV cycles later.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (clr)
            cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting sequencer: 1 Hz enable for the h/m/s counter plus the
// mode/inc/dec driven hour/minute set flow ending in a one-cycle load.
module clock_set_ctrl
    import clk_pkg::*;
#(
    parameter int TICK_DIV      = 50_000_000,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic [HOUR_W-1:0] cur_ora,
    input  logic [MIN_W-1:0]  cur_minut,
    output logic              enable,
    output logic              load,
    output logic [HOUR_W-1:0] ora_setata,
    output logic [MIN_W-1:0]  min_setat,
    output logic              set_hour,
    output logic              set_min
);

    localparam int              TO_W    = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [HOUR_W-1:0] ora_q, ora_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic              enable_q, enable_d;
    logic              load_q, load_d;
    logic              set_hour_q, set_min_q;
    logic              tick, pre_clr, any_btn;

    assign any_btn = btn_mode | btn_inc | btn_dec;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        to_d     = to_q;
        ora_d    = ora_q;
        min_d    = min_q;
        enable_d = 1'b0;
        load_d   = 1'b0;
        pre_clr  = 1'b0;
        case (state_q)
            RUN: begin
                enable_d = tick;
                if (btn_mode) begin
                    ora_d   = cur_ora;
                    min_d   = cur_minut;
                    to_d    = '0;
                    pre_clr = 1'b1;
                    state_d = SET_HOUR;
                end
            end
            SET_HOUR, SET_MIN: begin
                // Any press restarts the inactivity window; mode overrides inc/dec.
                if (any_btn) begin
                    to_d = '0;
                    if (btn_mode)
                        state_d = (state_q == SET_HOUR) ? SET_MIN : COMMIT;
                    else if (state_q == SET_HOUR)
                        ora_d = step_hour(ora_q, btn_inc, btn_dec);
                    else
                        min_d = step_min(min_q, btn_inc, btn_dec);
                end else if (tick) begin
                    if (to_q == TO_LAST) begin
                        to_d    = '0;
                        pre_clr = 1'b1;
                        state_d = RUN;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                load_d  = 1'b1;
                pre_clr = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // load surfaces the cycle after COMMIT, i.e. the first cycle back in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            to_q       <= '0;
            ora_q      <= '0;
            min_q      <= '0;
            enable_q   <= 1'b0;
            load_q     <= 1'b0;
            set_hour_q <= 1'b0;
            set_min_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            to_q       <= to_d;
            ora_q      <= ora_d;
            min_q      <= min_d;
            enable_q   <= enable_d;
            load_q     <= load_d;
            set_hour_q <= (state_d == SET_HOUR);
            set_min_q  <= (state_d == SET_MIN);
        end
    end

    assign enable     = enable_q;
    assign load       = load_q;
    assign ora_setata = ora_q;
    assign min_setat  = min_q;
    assign set_hour   = set_hour_q;
    assign set_min    = set_min_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with a cycle-level reference model
// and hand-computed literal expectations for each scenario.
module tb_clock_set_ctrl;

    localparam int TICK_DIV = 4;
    localparam int TIMEOUT  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [4:0] cur_ora = '0;
    logic [5:0] cur_minut = '0;
    logic       enable, load, set_hour, set_min;
    logic [4:0] ora_setata;
    logic [5:0] min_setat;

    int checks = 0;
    int passes = 0;

    clock_set_ctrl #(.TICK_DIV(TICK_DIV), .TIMEOUT_TICKS(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .cur_ora    (cur_ora),
        .cur_minut  (cur_minut),
        .enable     (enable),
        .load       (load),
        .ora_setata (ora_setata),
        .min_setat  (min_setat),
        .set_hour   (set_hour),
        .set_min    (set_min)
    );

    always #5 clk = ~clk;

    // Reference model: 0=run 1=set hour 2=set minute 3=commit.
    // m_since = cycles since the prescaler restarted; tick when it hits DIV-1 mod DIV.
    int m_st = 0, m_since = 0, m_idle = 0, m_h = 0, m_m = 0;
    int n_st, n_since, n_idle, n_h, n_m;
    bit m_tick, n_en, n_ld;
    bit m_valid = 1'b0;
    bit e_en, e_ld, e_sh, e_sm;
    int e_h, e_m;

    always_comb begin
        m_tick  = (m_since % TICK_DIV) == TICK_DIV - 1;
        n_st    = m_st;
        n_since = m_since + 1;
        n_idle  = m_idle;
        n_h     = m_h;
        n_m     = m_m;
        n_en    = 1'b0;
        n_ld    = 1'b0;
        case (m_st)
            0: begin
                n_en = m_tick;
                if (btn_mode) begin
                    n_h = int'(cur_ora); n_m = int'(cur_minut);
                    n_st = 1; n_since = 0; n_idle = 0;
                end
            end
            1, 2: begin
                if (btn_mode || btn_inc || btn_dec) begin
                    n_idle = 0;
                    if (btn_mode) n_st = m_st + 1;
                    else if (btn_inc && !btn_dec) begin
                        if (m_st == 1) n_h = (m_h + 1) % 24; else n_m = (m_m + 1) % 60;
                    end else if (btn_dec && !btn_inc) begin
                        if (m_st == 1) n_h = (m_h + 23) % 24; else n_m = (m_m + 59) % 60;
                    end
                end else if (m_tick) begin
                    n_idle = m_idle + 1;
                    if (n_idle == TIMEOUT) begin
                        n_st = 0; n_since = 0; n_idle = 0;
                    end
                end
            end
            default: begin
                n_ld = 1'b1; n_st = 0; n_since = 0;
            end
        endcase
    end

    always @(posedge clk) begin
        if (rst) begin
            m_st <= 0; m_since <= 0; m_idle <= 0; m_h <= 0; m_m <= 0;
            e_en <= 1'b0; e_ld <= 1'b0; e_sh <= 1'b0; e_sm <= 1'b0;
            e_h <= 0; e_m <= 0;
            m_valid <= 1'b1;
        end else begin
            m_st <= n_st; m_since <= n_since; m_idle <= n_idle; m_h <= n_h; m_m <= n_m;
            e_en <= n_en; e_ld <= n_ld;
            e_sh <= (n_st == 1); e_sm <= (n_st == 2);
            e_h <= n_h; e_m <= n_m;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if ($isunknown({enable, load, set_hour, set_min, ora_setata, min_setat}) ||
                enable !== e_en || load !== e_ld || set_hour !== e_sh || set_min !== e_sm ||
                int'(ora_setata) != e_h || int'(min_setat) != e_m || (enable && load))
                $display("FAIL model t=%0t got en=%b ld=%b sh=%b sm=%b h=%0d m=%0d want en=%b ld=%b sh=%b sm=%b h=%0d m=%0d",
                         $time, enable, load, set_hour, set_min, ora_setata, min_setat,
                         e_en, e_ld, e_sh, e_sm, e_h, e_m);
            else
                passes++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) $display("FAIL %s got %0d want %0d", nm, act, exp);
        else passes++;
    endtask

    task automatic pulse(input logic m, input logic i, input logic d);
        btn_mode = m; btn_inc = i; btn_dec = d;
        @(posedge clk); #1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_en"}, int'(enable), 0);
        chk({nm, "_ld"}, int'(load), 0);
        chk({nm, "_sh"}, int'(set_hour), 0);
        chk({nm, "_sm"}, int'(set_min), 0);
        chk({nm, "_h"}, int'(ora_setata), 0);
        chk({nm, "_m"}, int'(min_setat), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lcount;
        // 1: reset state and enable cadence
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("t1_rst");
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            chk("t1_en", int'(enable), (k % 4 == 0) ? 1 : 0);
            chk("t1_ld", int'(load), 0);
        end

        // 2: 05:30 -> +20 h, -31 min -> load 01:59
        cur_ora = 5'd5; cur_minut = 6'd30;
        pulse(1, 0, 0);
        chk("t2_sh", int'(set_hour), 1);
        chk("t2_cap_h", int'(ora_setata), 5);
        chk("t2_cap_m", int'(min_setat), 30);
        repeat (20) pulse(0, 1, 0);
        chk("t2_h", int'(ora_setata), 1);
        pulse(1, 0, 0);
        chk("t2_sm", int'(set_min), 1);
        repeat (31) pulse(0, 0, 1);
        chk("t2_m", int'(min_setat), 59);
        pulse(1, 0, 0);
        chk("t2_commit_ld", int'(load), 0);
        @(posedge clk); #1;
        chk("t2_ld", int'(load), 1);
        chk("t2_ld_en", int'(enable), 0);
        chk("t2_ld_h", int'(ora_setata), 1);
        chk("t2_ld_m", int'(min_setat), 59);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk("t2_en_after", int'(enable), (k == 4) ? 1 : 0);
            chk("t2_ld_once", int'(load), 0);
        end

        // 3: wrap boundaries and inc+dec cancel
        cur_ora = 5'd23; cur_minut = 6'd59;
        pulse(1, 0, 0);
        chk("t3_cap", int'(ora_setata), 23);
        pulse(0, 1, 0);
        chk("t3_h_inc_wrap", int'(ora_setata), 0);
        pulse(0, 0, 1);
        chk("t3_h_dec_wrap", int'(ora_setata), 23);
        pulse(0, 1, 1);
        chk("t3_h_both", int'(ora_setata), 23);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        chk("t3_m_inc_wrap", int'(min_setat), 0);
        pulse(0, 0, 1);
        chk("t3_m_dec_wrap", int'(min_setat), 59);
        pulse(1, 0, 0);
        @(posedge clk); #1;
        chk("t3_ld", int'(load), 1);
        chk("t3_ld_h", int'(ora_setata), 23);

        // 4: inactivity timeout from SET_HOUR
        pulse(1, 0, 0);
        chk("t4_sh", int'(set_hour), 1);
        lcount = 0;
        repeat (11) begin
            @(posedge clk); #1;
            if (load) lcount++;
        end
        chk("t4_sh_held", int'(set_hour), 1);
        @(posedge clk); #1;
        chk("t4_sh_drop", int'(set_hour), 0);
        chk("t4_ld", int'(load) + lcount, 0);

        // 5: reset in the middle of SET_MIN
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        chk("t5_sm", int'(set_min), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_all_zero("t5_rst");
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk("t5_en", int'(enable), (k == 4) ? 1 : 0);
        end

        // 6: mode+inc together in SET_HOUR -> mode wins
        cur_ora = 5'd10; cur_minut = 6'd7;
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        chk("t6_h", int'(ora_setata), 11);
        pulse(1, 1, 0);
        chk("t6_sm", int'(set_min), 1);
        chk("t6_sh", int'(set_hour), 0);
        chk("t6_h_kept", int'(ora_setata), 11);
        chk("t6_m_kept", int'(min_setat), 7);

        repeat (16) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
